// File: rtl/branch_flush_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : branch_flush_ctrl
// Brief    : Per-stage kill/stall control that squashes wrong-path work after
//            branch/JALR redirects and masks fetch during I-memory refill.
//            Define BRANCH_PERF_CNT_EN to build the redirect event counters.
// Revision : 1.0 - initial release
// ============================================================================
module branch_flush_ctrl #(
    parameter int REFILL_CYC = 1,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             predict_fail,
    input  logic [2:0]       pcmux_sel,
    input  logic             stall_in,
    input  logic             instF_valid,
    output logic             killF,
    output logic             killD,
    output logic             killE,
    output logic             stall_out,
    output logic             flush_busy,
    output logic [CNT_W-1:0] mispredict_cnt,
    output logic [CNT_W-1:0] jalr_cnt
);

    localparam logic [2:0] c_SEL_JALR    = 3'd4;
    localparam logic [2:0] c_REFILL_LOAD = 3'(REFILL_CYC - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_FLUSH  = 2'd1,
        S_REFILL = 2'd2
    } state_t;

    state_t     r_state;
    state_t     w_state_nxt;
    logic [2:0] r_refill_cnt;
    logic [2:0] w_refill_cnt_nxt;
    logic       r_kill_f;
    logic       r_kill_d;
    logic       r_kill_e;
    logic       w_kill_f_nxt;
    logic       w_kill_d_nxt;
    logic       w_kill_e_nxt;

    logic w_advance;
    logic w_br;
    logic w_jalr;
    logic w_redirect;

    // A stalled cycle accepts no redirect; branch outranks JALR.
    assign w_advance  = ~stall_in;
    assign w_br       = w_advance & predict_fail;
    assign w_jalr     = w_advance & ~predict_fail & (pcmux_sel == c_SEL_JALR);
    assign w_redirect = w_br | w_jalr;

    always_comb begin
        w_state_nxt      = r_state;
        w_refill_cnt_nxt = r_refill_cnt;
        if (w_redirect) begin
            w_state_nxt = S_FLUSH;
        end else if (w_advance) begin
            case (r_state)
                S_FLUSH: begin
                    w_refill_cnt_nxt = c_REFILL_LOAD;
                    w_state_nxt      = (c_REFILL_LOAD == 3'd0) ? S_IDLE : S_REFILL;
                end
                S_REFILL: begin
                    w_refill_cnt_nxt = r_refill_cnt - 3'd1;
                    if (r_refill_cnt <= 3'd1) begin
                        w_state_nxt = S_IDLE;
                    end
                end
                default: begin
                    w_state_nxt = S_IDLE;
                end
            endcase
        end
    end

    // killF stays forced for as long as the FSM remains out of IDLE.
    always_comb begin
        w_kill_f_nxt = r_kill_f;
        w_kill_d_nxt = r_kill_d;
        w_kill_e_nxt = r_kill_e;
        if (w_advance) begin
            w_kill_e_nxt = w_br ? 1'b1 : r_kill_d;
            w_kill_d_nxt = w_redirect ? 1'b1 : r_kill_f;
            w_kill_f_nxt = (w_state_nxt != S_IDLE) | ~instF_valid;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_refill_cnt <= 3'd0;
            r_kill_f     <= 1'b1;
            r_kill_d     <= 1'b1;
            r_kill_e     <= 1'b1;
        end else begin
            r_state      <= w_state_nxt;
            r_refill_cnt <= w_refill_cnt_nxt;
            r_kill_f     <= w_kill_f_nxt;
            r_kill_d     <= w_kill_d_nxt;
            r_kill_e     <= w_kill_e_nxt;
        end
    end

    assign killF      = r_kill_f;
    assign killD      = r_kill_d;
    assign killE      = r_kill_e;
    assign stall_out  = stall_in;
    assign flush_busy = (r_state != S_IDLE);

`ifdef BRANCH_PERF_CNT_EN
    localparam logic [CNT_W-1:0] c_CNT_ONE = CNT_W'(1);

    logic [CNT_W-1:0] r_mispredict_cnt;
    logic [CNT_W-1:0] r_jalr_cnt;

    // Saturating event counters, cleared only by reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mispredict_cnt <= '0;
            r_jalr_cnt       <= '0;
        end else begin
            if (w_br && !(&r_mispredict_cnt)) begin
                r_mispredict_cnt <= r_mispredict_cnt + c_CNT_ONE;
            end
            if (w_jalr && !(&r_jalr_cnt)) begin
                r_jalr_cnt <= r_jalr_cnt + c_CNT_ONE;
            end
        end
    end

    assign mispredict_cnt = r_mispredict_cnt;
    assign jalr_cnt       = r_jalr_cnt;
`else
    assign mispredict_cnt = '0;
    assign jalr_cnt       = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_branch_flush_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_branch_flush_ctrl
// Brief    : Self-checking bench: two instances (REFILL_CYC=2/CNT_W=4 and
//            REFILL_CYC=1/CNT_W=16) checked every cycle against a window model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_branch_flush_ctrl;

`ifdef BRANCH_PERF_CNT_EN
    localparam int PERF = 1;
`else
    localparam int PERF = 0;
`endif
    localparam int R0 = 2;
    localparam int R1 = 1;
    localparam int CMAX0 = 15;
    localparam int CMAX1 = 65535;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       predict_fail = 1'b0;
    logic [2:0] pcmux_sel = 3'd0;
    logic       stall_in = 1'b0;
    logic       instF_valid = 1'b0;

    logic kf0, kd0, ke0, so0, fb0;
    logic kf1, kd1, ke1, so1, fb1;
    logic [3:0]  mc0, jc0;
    logic [15:0] mc1, jc1;

    int n_checks = 0;
    int n_err    = 0;
    bit chk_en   = 1'b0;

    // Model: each instance keeps the number of remaining "busy" cycles.
    logic mF[2] = '{1'b1, 1'b1};
    logic mD[2] = '{1'b1, 1'b1};
    logic mE[2] = '{1'b1, 1'b1};
    int   mrem[2] = '{0, 0};
    int   mmis[2] = '{0, 0};
    int   mjal[2] = '{0, 0};

    always #5 clk = ~clk;

    branch_flush_ctrl #(.REFILL_CYC(R0), .CNT_W(4)) u_dut0 (
        .clk(clk), .rst(rst), .predict_fail(predict_fail), .pcmux_sel(pcmux_sel),
        .stall_in(stall_in), .instF_valid(instF_valid),
        .killF(kf0), .killD(kd0), .killE(ke0), .stall_out(so0), .flush_busy(fb0),
        .mispredict_cnt(mc0), .jalr_cnt(jc0)
    );

    branch_flush_ctrl #(.REFILL_CYC(R1), .CNT_W(16)) u_dut1 (
        .clk(clk), .rst(rst), .predict_fail(predict_fail), .pcmux_sel(pcmux_sel),
        .stall_in(stall_in), .instF_valid(instF_valid),
        .killF(kf1), .killD(kd1), .killE(ke1), .stall_out(so1), .flush_busy(fb1),
        .mispredict_cnt(mc1), .jalr_cnt(jc1)
    );

    function automatic bit is_redirect();
        return predict_fail || (pcmux_sel == 3'd4);
    endfunction

    function automatic int rem_after(input int i);
        if (is_redirect()) return (i == 0) ? R0 : R1;
        return (mrem[i] > 0) ? mrem[i] - 1 : 0;
    endfunction

    function automatic int cmax(input int i);
        return (i == 0) ? CMAX0 : CMAX1;
    endfunction

    always @(posedge clk or posedge rst) begin
        for (int i = 0; i < 2; i++) begin
            if (rst) begin
                mF[i] <= 1'b1; mD[i] <= 1'b1; mE[i] <= 1'b1;
                mrem[i] <= 0; mmis[i] <= 0; mjal[i] <= 0;
            end else if (!stall_in) begin
                mE[i]   <= predict_fail ? 1'b1 : mD[i];
                mD[i]   <= is_redirect() ? 1'b1 : mF[i];
                mrem[i] <= rem_after(i);
                mF[i]   <= (rem_after(i) > 0) ? 1'b1 : !instF_valid;
                if (PERF == 1 && predict_fail && mmis[i] < cmax(i))
                    mmis[i] <= mmis[i] + 1;
                if (PERF == 1 && !predict_fail && pcmux_sel == 3'd4 && mjal[i] < cmax(i))
                    mjal[i] <= mjal[i] + 1;
            end
        end
    end

    task automatic check(input string name, input int i, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s[dut%0d]: got %0d expected %0d @%0t", name, i, act, exp, $time);
        end
    endtask

    task automatic cmp_inst(input int i, input logic kf, input logic kd, input logic ke,
                            input logic so, input logic fb, input int mc, input int jc);
        check("killF", i, int'(kf), int'(mF[i]));
        check("killD", i, int'(kd), int'(mD[i]));
        check("killE", i, int'(ke), int'(mE[i]));
        check("stall_out", i, int'(so), int'(stall_in));
        check("flush_busy", i, int'(fb), (mrem[i] > 0) ? 1 : 0);
        check("mispredict_cnt", i, mc, mmis[i]);
        check("jalr_cnt", i, jc, mjal[i]);
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            cmp_inst(0, kf0, kd0, ke0, so0, fb0, int'(mc0), int'(jc0));
            cmp_inst(1, kf1, kd1, ke1, so1, fb1, int'(mc1), int'(jc1));
        end
    end

    task automatic tick(input logic pf, input logic [2:0] sel, input logic st, input logic v);
        predict_fail = pf; pcmux_sel = sel; stall_in = st; instF_valid = v;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        predict_fail = 1'b0; pcmux_sel = 3'd0; stall_in = 1'b0; instF_valid = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic lit_kills0(input string tag, input int f, input int d, input int e, input int b);
        check({tag, ".killF"}, 0, int'(kf0), f);
        check({tag, ".killD"}, 0, int'(kd0), d);
        check({tag, ".killE"}, 0, int'(ke0), e);
        check({tag, ".busy"},  0, int'(fb0), b);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk_en = 1'b1;
        lit_kills0("rst", 1, 1, 1, 0);
        check("rst.mis", 0, int'(mc0), 0);
        rst = 1'b0;

        // Pipeline fills from empty.
        tick(1'b0, 3'd0, 1'b0, 1'b1); lit_kills0("fill1", 0, 1, 1, 0);
        tick(1'b0, 3'd0, 1'b0, 1'b1); lit_kills0("fill2", 0, 0, 1, 0);
        tick(1'b0, 3'd0, 1'b0, 1'b1); lit_kills0("fill3", 0, 0, 0, 0);

        // Branch mispredict in steady flow.
        tick(1'b1, 3'd5, 1'b0, 1'b1); lit_kills0("br1", 1, 1, 1, 1);
        check("br1.mis", 0, int'(mc0), PERF);
        check("br1.busy", 1, int'(fb1), 1);
        tick(1'b0, 3'd0, 1'b0, 1'b1); lit_kills0("br2", 1, 1, 1, 1);
        check("br2.killF", 1, int'(kf1), 0);
        check("br2.busy", 1, int'(fb1), 0);
        tick(1'b0, 3'd0, 1'b0, 1'b1); lit_kills0("br3", 0, 1, 1, 0);
        repeat (3) tick(1'b0, 3'd0, 1'b0, 1'b1);

        // JALR with a valid E-stage instruction.
        tick(1'b0, 3'd4, 1'b0, 1'b1); lit_kills0("jalr", 1, 1, 0, 1);
        check("jalr.cnt", 0, int'(jc0), PERF);
        repeat (5) tick(1'b0, 3'd0, 1'b0, 1'b1);

        // Redirect requests are ignored while stalled.
        for (int k = 0; k < 3; k++) begin
            tick(1'b1, 3'd5, 1'b1, 1'b1);
            lit_kills0("stall", 0, 0, 0, 0);
            check("stall.out", 0, int'(so0), 1);
            check("stall.mis", 0, int'(mc0), PERF);
        end
        tick(1'b0, 3'd0, 1'b0, 1'b1); lit_kills0("unstall", 0, 0, 0, 0);

        // Second mispredict lands in REFILL and restarts the window.
        tick(1'b1, 3'd5, 1'b0, 1'b1); lit_kills0("re1", 1, 1, 1, 1);
        tick(1'b0, 3'd0, 1'b0, 1'b1); lit_kills0("re2", 1, 1, 1, 1);
        tick(1'b1, 3'd5, 1'b0, 1'b1); lit_kills0("re3", 1, 1, 1, 1);
        tick(1'b0, 3'd0, 1'b0, 1'b1); lit_kills0("re4", 1, 1, 1, 1);
        tick(1'b0, 3'd0, 1'b0, 1'b1); lit_kills0("re5", 0, 1, 1, 0);
        check("re.mis", 0, int'(mc0), 3 * PERF);

        // Randomized traffic against the model.
        for (int k = 0; k < 600; k++) begin
            if ($urandom_range(0, 149) == 0) begin
                do_reset();
            end else begin
                tick(($urandom_range(0, 7) == 0), 3'($urandom_range(0, 7)),
                     ($urandom_range(0, 4) == 0), ($urandom_range(0, 5) != 0));
            end
        end

        // Counter saturation.
        do_reset();
        repeat (20) tick(1'b1, 3'd5, 1'b0, 1'b1);
        check("sat.mis", 0, int'(mc0), 15 * PERF);
        check("sat.mis", 1, int'(mc1), 20 * PERF);

        // Asynchronous reset in the middle of REFILL.
        tick(1'b0, 3'd0, 1'b0, 1'b1);
        tick(1'b1, 3'd5, 1'b0, 1'b1);
        tick(1'b0, 3'd0, 1'b0, 1'b1);
        check("mid.busy_pre", 0, int'(fb0), 1);
        rst = 1'b1;
        #2;
        lit_kills0("midrst", 1, 1, 1, 0);
        check("midrst.mis", 0, int'(mc0), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (4) tick(1'b0, 3'd0, 1'b0, 1'b1);
        lit_kills0("post", 0, 0, 0, 0);

        @(negedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/branch_flush_ctrl.md
# branch_flush_ctrl

- Pipeline-control partner of the static branch predictor.
- Consumes the predictor's `predict_fail`/`pcmux_sel` decisions and produces the per-stage kill flags (`killF`, `killD`, `killE`) and `stall_out` that the predictor and pipeline registers consume.
- Tracks bubble state per stage, squashes wrong-path instructions after a redirect, and masks fetch during instruction-memory refill.
- Optionally counts redirect events for performance analysis.

## Interface
Parameters:
- `REFILL_CYC`, default 1: cycles `killF` is forced after a redirect (instruction-memory latency); legal range 1–7.
- `CNT_W`, default 16: width of performance counters.

Ports:
- `clk`  in  1  single clock; all state updates on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `predict_fail`  in  1  E-stage branch resolved against prediction (redirect to branch target).
- `pcmux_sel`  in  3  PC source selected this cycle: 0/1 = sequential, 3 = JAL (F), 4 = JALR (D), 5 = branch (E).
- `stall_in`  in  1  hazard-unit stall request.
- `instF_valid`  in  1  instruction memory returned a valid word into F this cycle.
- `killF`  out  1  F holds a bubble.
- `killD`  out  1  D holds a bubble.
- `killE`  out  1  E holds a bubble.
- `stall_out`  out  1  pipeline hold to PC and F/D/E registers.
- `flush_busy`  out  1  high while in FLUSH or REFILL.
- `mispredict_cnt`  out  CNT_W  count of accepted `predict_fail` events.
- `jalr_cnt`  out  CNT_W  count of accepted `pcmux_sel==4` events.

## Operation
- Reset values:
  - `killF`, `killD`, `killE` = 1 (empty pipeline).
  - `stall_out` = `stall_in`.
  - `flush_busy` = 0.
  - State = IDLE; refill counter = 0; both counters = 0.
- `stall_out = stall_in` (combinational).
- While `stall_in = 1`:
  - All kill flags, state and counters hold.
  - `predict_fail` and `pcmux_sel` are ignored.
- Normal advance (`stall_in = 0`, no redirect): `killE <= killD`, `killD <= killF`, `killF <= ~instF_valid`.
- Branch redirect (`predict_fail = 1`, accepted):
  - `killE <= 1` and `killD <= 1` (wrong-path F and D are squashed).
  - `killF <= 1`; enter FLUSH.
  - Priority over `pcmux_sel`.
- JALR redirect (`pcmux_sel == 4`, no `predict_fail`):
  - `killE <= killD` (JALR proceeds).
  - `killD <= 1` (wrong-path F squashed).
  - `killF <= 1`; enter FLUSH.
- JAL (`pcmux_sel == 3`): no squash; normal advance.
- FSM:
  - IDLE: on an accepted redirect, go to FLUSH.
  - FLUSH: lasts one cycle; `killF` forced 1; load refill counter with `REFILL_CYC-1`. If the counter is 0, go to IDLE, otherwise go to REFILL.
  - REFILL: `killF` forced 1; counter decrements each unstalled cycle; go to IDLE when it reaches 0.
- Redirect accepted in FLUSH or REFILL re-enters FLUSH; the counter restarts.
- `flush_busy = (state != IDLE)`.
- Reset asserted mid-flush: immediate return to reset values; no pending squash survives.

## Timing
- All kill flags are registered: a redirect accepted in cycle N is visible in the kill outputs in cycle N+1.
- Branch redirect at N:
  - N+1: `killF=killD=killE=1`.
  - N+1 .. N+REFILL_CYC: `killF=1`.
  - N+REFILL_CYC+1: `killF = ~instF_valid`.
- JALR at N: N+1 `killD=1`, `killE=` previous `killD`.
- A stall stretches every interval by its length; a stalled cycle never decrements the refill counter.

## Configuration
- `BRANCH_PERF_CNT_EN` defined:
  - `mispredict_cnt` increments on each accepted `predict_fail`.
  - `jalr_cnt` increments on each accepted JALR redirect.
  - Both saturate at all-ones and are cleared only by `rst`.
- Not defined: both outputs tied to 0; no counter flops are synthesized.

## Test plan
- Reset, then `instF_valid=1` each cycle: kills are 1/1/1 after reset → 0/1/1 → 0/0/1 → 0/0/0 on successive edges.
- Steady flow, `predict_fail=1` for one cycle, `REFILL_CYC=2`:
  - next two cycles `killF=1`, `flush_busy=1`.
  - first cycle `killD=killE=1`.
  - `mispredict_cnt` = 1 (macro on) or 0 (macro off).
- `pcmux_sel=4` with E valid: next cycle `killD=1`, `killE=0`; `jalr_cnt=1`.
- `predict_fail=1` together with `stall_in=1` for 3 cycles, then both low: kills unchanged throughout, state stays IDLE, counter stays 0.
- `predict_fail` pulsed again during REFILL: FLUSH re-entered and `killF` stays 1 for a further `REFILL_CYC` cycles.
- Counter saturation with `CNT_W=4`: 20 accepted mispredicts → `mispredict_cnt=15`. Separately, `rst` pulsed mid-REFILL: kills return to 1/1/1, `flush_busy=0`.
